// File: rtl/imem_loader_if.sv
// Host word stream plus instruction-RAM write port used by the imem_loader.
// The slave side is the loader; the master side is the host/bench.
interface imem_loader_if #(
    parameter int ADDR_W = 5
) ();
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_last;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Streams host words into the instruction RAM and holds the CPU in reset until loaded.
// Optional checksum stage enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH       = 28,
    parameter int ADDR_W      = 5,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    imem_loader_if.slave      bus,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM = 3'd2,
`endif
        S_HOLD = 3'd3,
        S_RUN  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [3:0]      HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t              state_reg;
    logic                imem_we_reg;
    logic [ADDR_W-1:0]   imem_addr_reg;
    logic [31:0]         imem_wdata_reg;
    logic                cpu_reset_reg;
    logic                done_reg;
    logic                error_reg;
    logic [ADDR_W:0]     word_count_reg;
    logic [3:0]          hold_cnt_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]         sum_reg;
`endif

    logic in_ready;
    logic beat;
    logic load_req;

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign in_ready = (state_reg == S_LOAD) || (state_reg == S_CSUM);
`else
    assign in_ready = (state_reg == S_LOAD);
`endif

    assign beat     = bus.in_valid && in_ready;
    assign load_req = start && ((state_reg == S_IDLE) ||
                                (state_reg == S_RUN)  ||
                                (state_reg == S_ERR));

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            imem_we_reg    <= 1'b0;
            imem_addr_reg  <= '0;
            imem_wdata_reg <= '0;
            cpu_reset_reg  <= 1'b1;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            word_count_reg <= '0;
            hold_cnt_reg   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_reg        <= '0;
`endif
        end else begin
            imem_we_reg <= 1'b0;
            if (load_req) begin
                // Every accepted start funnels into a fresh load from address 0.
                state_reg      <= S_LOAD;
                cpu_reset_reg  <= 1'b1;
                done_reg       <= 1'b0;
                error_reg      <= 1'b0;
                word_count_reg <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_reg        <= '0;
`endif
            end else begin
                case (state_reg)
                    S_LOAD: begin
                        if (beat) begin
                            if (word_count_reg < DEPTH_CNT) begin
                                imem_we_reg    <= 1'b1;
                                imem_addr_reg  <= word_count_reg[ADDR_W-1:0];
                                imem_wdata_reg <= bus.in_data;
                                word_count_reg <= word_count_reg + CNT_ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                                sum_reg        <= sum_reg + bus.in_data;
`endif
                                if (bus.in_last) begin
                                    hold_cnt_reg <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                                    state_reg    <= S_CSUM;
`else
                                    state_reg    <= S_HOLD;
`endif
                                end
                            end else begin
                                // RAM full: the overflowing word is dropped.
                                state_reg <= S_ERR;
                                error_reg <= 1'b1;
                            end
                        end
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        if (beat) begin
                            if (bus.in_data == sum_reg) begin
                                state_reg    <= S_HOLD;
                                hold_cnt_reg <= '0;
                            end else begin
                                state_reg <= S_ERR;
                                error_reg <= 1'b1;
                            end
                        end
                    end
`endif
                    S_HOLD: begin
                        // Last write lands one cycle after its beat, so any
                        // HOLD_CYCLES >= 1 releases the CPU after it.
                        if (hold_cnt_reg == HOLD_LAST) begin
                            cpu_reset_reg <= 1'b0;
                            done_reg      <= 1'b1;
                            state_reg     <= S_RUN;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg + 4'd1;
                        end
                    end
                    S_IDLE, S_RUN, S_ERR: begin
                        state_reg <= state_reg;
                    end
                    default: begin
                        state_reg     <= S_IDLE;
                        cpu_reset_reg <= 1'b1;
                        done_reg      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.imem_we    = imem_we_reg;
    assign bus.imem_addr  = imem_addr_reg;
    assign bus.imem_wdata = imem_wdata_reg;
    assign cpu_reset      = cpu_reset_reg;
    assign done           = done_reg;
    assign error          = error_reg;
    assign word_count     = word_count_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a vector table for the basic load plus
// hand-written sequences for gapped input, reload, overflow, reset and checksum.
module tb_imem_loader;

    logic       CLK = 1'b0;
    logic       reset;
    logic       start;
    logic       cpu_reset;
    logic       done;
    logic       error;
    logic [5:0] word_count;

    imem_loader_if #(.ADDR_W(5)) bus ();

    imem_loader #(.DEPTH(28), .ADDR_W(5), .HOLD_CYCLES(2)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        s;
        logic        v;
        logic        l;
        logic [31:0] d;
        logic        e_rdy;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_wdata;
        logic        e_cr;
        logic        e_done;
        logic        e_err;
        logic [5:0]  e_wc;
    } vec_t;

    vec_t vt[$];

    logic [31:0] words [5] = '{32'h20020005, 32'h2003000C, 32'h2067FFF7,
                               32'h00E22025, 32'h00642824};
    logic [31:0] sum5;
    logic [31:0] sum3;

    function automatic vec_t mk(input logic s, input logic v, input logic l,
                                input logic [31:0] d, input logic rdy,
                                input logic we, input logic [4:0] a,
                                input logic [31:0] wd, input logic cr,
                                input logic dn, input logic er,
                                input logic [5:0] wc);
        vec_t r;
        r.s = s; r.v = v; r.l = l; r.d = d;
        r.e_rdy = rdy; r.e_we = we; r.e_addr = a; r.e_wdata = wd;
        r.e_cr = cr; r.e_done = dn; r.e_err = er; r.e_wc = wc;
        return r;
    endfunction

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic s, input logic v, input logic l,
                         input logic [31:0] d);
        start        = s;
        bus.in_valid = v;
        bus.in_last  = l;
        bus.in_data  = d;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic rdy, input logic cr,
                              input logic dn, input logic er,
                              input logic [5:0] wc);
        chk({tag, ".in_ready"},   32'(bus.in_ready), 32'(rdy));
        chk({tag, ".cpu_reset"},  32'(cpu_reset),    32'(cr));
        chk({tag, ".done"},       32'(done),         32'(dn));
        chk({tag, ".error"},      32'(error),        32'(er));
        chk({tag, ".word_count"}, 32'(word_count),   32'(wc));
    endtask

    task automatic chk_write(input string tag, input logic we,
                             input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".imem_we"}, 32'(bus.imem_we), 32'(we));
        if (we) begin
            chk({tag, ".imem_addr"},  32'(bus.imem_addr), 32'(a));
            chk({tag, ".imem_wdata"}, bus.imem_wdata,     d);
        end
    endtask

    // Releases the CPU two edges after the last data beat (or checksum beat).
    task automatic finish_load(input string tag, input logic [31:0] sum,
                               input logic [5:0] wc);
`ifdef IMEM_LOADER_CHECKSUM_EN
        drive(0, 1, 0, sum);
        cyc();
        chk_write({tag, ".csum"}, 0, 5'd0, 32'd0);
`else
        chk({tag, ".sum_known"}, sum, sum);
        total--;
`endif
        drive(0, 0, 0, 32'd0);
        cyc();
        chk_status({tag, ".hold1"}, 0, 1, 0, 0, wc);
        cyc();
        chk_status({tag, ".run"}, 0, 0, 1, 0, wc);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sum5 = '0;
        for (int i = 0; i < 5; i++) sum5 = sum5 + words[i];
        sum3 = words[0] + words[1] + words[2];

        // Reset held two cycles with start and in_valid asserted.
        reset = 1'b0;
        drive(1, 1, 0, 32'hCAFEF00D);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk_status($sformatf("rst%0d", i), 0, 1, 0, 0, 6'd0);
            chk($sformatf("rst%0d.imem_we", i), 32'(bus.imem_we), 32'd0);
            chk($sformatf("rst%0d.imem_addr", i), 32'(bus.imem_addr), 32'd0);
            chk($sformatf("rst%0d.imem_wdata", i), bus.imem_wdata, 32'd0);
        end
        reset = 1'b1;
        drive(0, 0, 0, 32'd0);
        cyc();
        chk_status("idle", 0, 1, 0, 0, 6'd0);

        // Basic five-word load from IDLE.
        vt.push_back(mk(1, 1, 0, 32'hDEADBEEF, 1, 0, 5'd0, 32'd0, 1, 0, 0, 6'd0));
        for (int k = 0; k < 4; k++)
            vt.push_back(mk(0, 1, 0, words[k], 1, 1, 5'(k), words[k], 1, 0, 0, 6'(k + 1)));
`ifdef IMEM_LOADER_CHECKSUM_EN
        vt.push_back(mk(0, 1, 1, words[4], 1, 1, 5'd4, words[4], 1, 0, 0, 6'd5));
        vt.push_back(mk(0, 1, 0, sum5,     0, 0, 5'd0, 32'd0,    1, 0, 0, 6'd5));
`else
        vt.push_back(mk(0, 1, 1, words[4], 0, 1, 5'd4, words[4], 1, 0, 0, 6'd5));
`endif
        vt.push_back(mk(0, 0, 0, 32'd0,        0, 0, 5'd0, 32'd0, 1, 0, 0, 6'd5));
        vt.push_back(mk(0, 0, 0, 32'd0,        0, 0, 5'd0, 32'd0, 0, 1, 0, 6'd5));
        vt.push_back(mk(0, 1, 1, 32'h12345678, 0, 0, 5'd0, 32'd0, 0, 1, 0, 6'd5));
        vt.push_back(mk(0, 0, 0, 32'd0,        0, 0, 5'd0, 32'd0, 0, 1, 0, 6'd5));

        foreach (vt[i]) begin
            drive(vt[i].s, vt[i].v, vt[i].l, vt[i].d);
            cyc();
            chk_status($sformatf("vec%0d", i), vt[i].e_rdy, vt[i].e_cr,
                       vt[i].e_done, vt[i].e_err, vt[i].e_wc);
            chk_write($sformatf("vec%0d", i), vt[i].e_we, vt[i].e_addr, vt[i].e_wdata);
        end
        $display("table: %0d vectors applied", vt.size());

        // Restart from RUN, then five words with in_valid toggling.
        drive(1, 0, 0, 32'd0);
        cyc();
        chk_status("restart", 1, 1, 0, 0, 6'd0);
        for (int k = 0; k < 9; k++) begin
            drive(0, (k % 2) == 0, k == 8, words[k / 2]);
            cyc();
            chk_write($sformatf("gap%0d", k), (k % 2) == 0, 5'(k / 2), words[k / 2]);
            if (k < 8) chk($sformatf("gap%0d.in_ready", k), 32'(bus.in_ready), 32'd1);
        end
        chk("gap.word_count", 32'(word_count), 32'd5);
        finish_load("gap", sum5, 6'd5);

        // Reload three words.
        drive(1, 0, 0, 32'd0);
        cyc();
        chk_status("reload.start", 1, 1, 0, 0, 6'd0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, k == 2, words[k]);
            cyc();
            chk_write($sformatf("reload%0d", k), 1, 5'(k), words[k]);
        end
        chk("reload.word_count", 32'(word_count), 32'd3);
        finish_load("reload", sum3, 6'd3);

        // Overflow: 29 words with no in_last.
        drive(1, 0, 0, 32'd0);
        cyc();
        for (int k = 0; k < 29; k++) begin
            drive(0, 1, 0, 32'h1000_0000 + 32'(k));
            cyc();
            if (k < 28) begin
                chk_write($sformatf("ovf%0d", k), 1, 5'(k), 32'h1000_0000 + 32'(k));
            end else begin
                chk_write("ovf28", 0, 5'd0, 32'd0);
                chk_status("ovf28", 0, 1, 0, 1, 6'd28);
            end
        end
        drive(0, 0, 0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk_status($sformatf("err%0d", k), 0, 1, 0, 1, 6'd28);
        end
        drive(1, 0, 0, 32'd0);
        cyc();
        chk_status("err.restart", 1, 1, 0, 0, 6'd0);

        // Reset in the middle of a load.
        drive(0, 1, 0, 32'hAAAA5555);
        cyc();
        chk_write("midrst.beat", 1, 5'd0, 32'hAAAA5555);
        reset = 1'b0;
        cyc();
        chk_status("midrst", 0, 1, 0, 0, 6'd0);
        chk("midrst.imem_we", 32'(bus.imem_we), 32'd0);
        chk("midrst.imem_addr", 32'(bus.imem_addr), 32'd0);
        chk("midrst.imem_wdata", bus.imem_wdata, 32'd0);
        reset = 1'b1;
        drive(0, 0, 0, 32'd0);
        cyc();
        chk_status("midrst.idle", 0, 1, 0, 0, 6'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Good checksum then bad checksum.
        for (int pass = 0; pass < 2; pass++) begin
            drive(1, 0, 0, 32'd0);
            cyc();
            for (int k = 0; k < 3; k++) begin
                drive(0, 1, k == 2, 32'(k + 1));
                cyc();
                chk_write($sformatf("cs%0d.w%0d", pass, k), 1, 5'(k), 32'(k + 1));
            end
            chk($sformatf("cs%0d.in_ready", pass), 32'(bus.in_ready), 32'd1);
            if (pass == 0) begin
                finish_load("cs0", 32'd6, 6'd3);
            end else begin
                drive(0, 1, 0, 32'd7);
                cyc();
                chk_write("cs1.csum", 0, 5'd0, 32'd0);
                chk_status("cs1.err", 0, 1, 0, 1, 6'd3);
                drive(0, 0, 0, 32'd0);
                cyc();
                chk_status("cs1.err2", 0, 1, 0, 1, 6'd3);
            end
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the 5-stage MIPS pipeline. It accepts instruction words from a host over a valid/ready stream and writes them into the instruction RAM through its write port. The datapath's active-high `reset` is held asserted during the load and released a fixed number of cycles after the final write. It sits between the host/bench stimulus source and the `datapath` instruction memory, and supplies the program that the datapath then fetches.

## Interface
- `DEPTH`, 28: instruction RAM capacity in 32-bit words. Addresses run 0 .. DEPTH-1.
- `ADDR_W`, 5: word-address width. Must satisfy 2^ADDR_W ≥ DEPTH.
- `HOLD_CYCLES`, 2: cycles the CPU stays in reset after the final write, range 1..15.

- `CLK`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low reset. It is sampled at posedge `CLK`; 0 resets the block.
- `start`  in  1  single-cycle request to begin a load.
- `in_valid`  in  1  host word valid.
- `in_data`  in  32  host word (instruction, or checksum when enabled).
- `in_last`  in  1  marks the final instruction word.
- `in_ready`  out  1  loader accepts a word this cycle.
- `imem_we`  out  1  instruction RAM write enable.
- `imem_addr`  out  ADDR_W  instruction RAM word address.
- `imem_wdata`  out  32  instruction RAM write data.
- `cpu_reset`  out  1  active-high reset to `datapath`.
- `done`  out  1  program loaded, CPU running.
- `error`  out  1  load aborted (overflow or checksum mismatch).
- `word_count`  out  ADDR_W+1  number of words written in the current or most recent load.

## Operation
- States are IDLE, LOAD, CSUM (only with the macro), HOLD, RUN and ERR.
- On reset: state IDLE, `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_reset`=1, `done`=0, `error`=0, `word_count`=0, hold counter=0.
- IDLE:
  - `start`=1 moves to LOAD and clears `word_count`, `error` and `done`.
  - `cpu_reset` stays 1.
- LOAD:
  - `in_ready`=1 (decoded combinationally from state).
  - A beat transfers when `in_valid` && `in_ready`.
  - Each accepted beat with `word_count` < DEPTH writes `in_data` to address `word_count` and increments `word_count`.
  - A beat with `in_last`=1 is written, then the block goes to HOLD (or to CSUM if the macro is defined).
  - A beat accepted while `word_count`==DEPTH is dropped, not written, and the block goes to ERR. `in_last` on word DEPTH-1 is legal.
- HOLD:
  - The hold counter counts 0 .. HOLD_CYCLES-1.
  - On the terminal count: `cpu_reset`←0, `done`←1, go to RUN.
- RUN:
  - `cpu_reset`=0 and `done`=1.
  - `start`=1 reloads: `cpu_reset`←1, `done`←0, `word_count`←0 on the same edge, then LOAD.
- ERR:
  - `error`=1, `cpu_reset`=1, `in_ready`=0.
  - `start`=1 moves to LOAD and clears `error`.
- `start` is ignored in LOAD, CSUM and HOLD.
- `in_valid` is ignored outside LOAD and CSUM.
- The host may hold `in_valid` high indefinitely. Data is consumed only when `in_ready`=1.

## Timing
- Write latency is 1 cycle: a beat accepted at edge N gives `imem_we`=1, `imem_addr`/`imem_wdata` valid during cycle N+1. These are registered outputs. `imem_we` is high for exactly one cycle per accepted word.
- Throughput is one word per cycle. Back-to-back beats produce consecutive addresses with no gaps.
- `start` seen at edge S makes `in_ready`=1 from cycle S+1. A beat presented in the same cycle as `start` is not accepted.
- Last beat at edge L: its write occurs in cycle L+1. Without the macro, `cpu_reset` falls at edge L+HOLD_CYCLES. The final write therefore always completes before the CPU leaves reset.
- Reset mid-load: the next edge returns to IDLE with all outputs at reset values. The RAM contents are left as written; they are not cleared.

## Configuration
- Macro `IMEM_LOADER_CHECKSUM_EN`.
- **Defined:**
  - The loader keeps a 32-bit wrap-around sum of all written words.
  - After the `in_last` beat it enters CSUM with `in_ready`=1.
  - The next accepted beat is the checksum and is not written to RAM.
  - Checksum equal to the sum: go to HOLD, with `cpu_reset` falling HOLD_CYCLES edges after the checksum beat.
  - Checksum not equal: go to ERR.
- **Undefined:** the CSUM state and the sum logic are absent. `in_last` goes straight to HOLD.

## Test plan
- Reset with `reset`=0 for 2 cycles while `start`=1 and `in_valid`=1 -> every output at its reset value, no `imem_we` pulse, `cpu_reset`=1.
- `start`, then 5 back-to-back words 0x20020005, 0x2003000C, 0x2067FFF7, 0x00E22025, 0x00642824 with `in_last` on the 5th -> five `imem_we` pulses at addresses 0..4 carrying that data in order, `word_count`=5, `cpu_reset` falls 2 edges after the last beat, `done`=1.
- Same 5 words with `in_valid` toggling 1/0 every cycle -> same writes, `in_ready` constantly 1, addresses still 0..4 with no skips.
- 29 words with no `in_last` -> 28 writes at addresses 0..27, 29th word dropped, `error`=1, `cpu_reset` stays 1. A following `start` clears `error`.
- In RUN, pulse `start` -> `cpu_reset`=1 and `done`=0 the next cycle. Reload of 3 words writes addresses 0..2, `word_count`=3.
- With `IMEM_LOADER_CHECKSUM_EN`: words 1, 2, 3 (`in_last` on 3), then checksum 6 -> RUN. Repeating with checksum 7 -> ERR, no 4th write, `cpu_reset`=1.
